// File: rtl/ai_ram_read_scheduler_if.sv
// Bundle of the signals between the AI RAM read scheduler, its two compute engines
// and the RAM inside read port.
//   req0/req1 : address-pair requests {addr2,addr1} (valid/ready)
//   rsp0/rsp1 : per-engine in-order responses {data2,data1} (valid/ready)
//   ram_*     : address pair to the RAM (valid/ready) and its fixed-latency read data
//   busy      : reads in flight or responses still queued
// Handshake rule for every valid/ready pair here: a transfer happens in exactly the
// cycle where valid and ready are both high at the rising clock edge.
// Modports: slave = the scheduler itself, master = the surrounding environment.
interface ai_ram_read_scheduler_if;
    logic        req0_valid;
    logic [31:0] req0_addr;
    logic        req0_ready;
    logic        rsp0_valid;
    logic [63:0] rsp0_data;
    logic        rsp0_ready;
    logic        req1_valid;
    logic [31:0] req1_addr;
    logic        req1_ready;
    logic        rsp1_valid;
    logic [63:0] rsp1_data;
    logic        rsp1_ready;
    logic [31:0] ram_addr;
    logic        ram_addr_valid;
    logic        ram_addr_ready;
    logic [63:0] ram_data;
    logic        busy;

    modport slave (
        input  req0_valid, req0_addr, rsp0_ready,
        input  req1_valid, req1_addr, rsp1_ready,
        input  ram_addr_ready, ram_data,
        output req0_ready, rsp0_valid, rsp0_data,
        output req1_ready, rsp1_valid, rsp1_data,
        output ram_addr, ram_addr_valid, busy
    );

    modport master (
        output req0_valid, req0_addr, rsp0_ready,
        output req1_valid, req1_addr, rsp1_ready,
        output ram_addr_ready, ram_data,
        input  req0_ready, rsp0_valid, rsp0_data,
        input  req1_ready, rsp1_valid, rsp1_data,
        input  ram_addr, ram_addr_valid, busy
    );
endinterface

// File: rtl/ai_ram_read_scheduler.sv
// Shares the AI RAM dual-address read port between two compute engines.
// Round-robin grant between eligible requesters, a RD_LATENCY-deep tag pipe that
// remembers which engine each in-flight read belongs to, and one credit-guarded
// show-ahead response FIFO per engine so each engine sees its data in issue order.
// Ports:
//   csi_clk      clock
//   rsi_reset_n  asynchronous active-low reset
//   bus          ai_ram_read_scheduler_if.slave (requests, responses, RAM port, busy)
module ai_ram_read_scheduler #(
    parameter int RD_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    csi_clk,
    input  logic                    rsi_reset_n,
    ai_ram_read_scheduler_if.slave  bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [1:0]            req_valid;
    logic [1:0]            rsp_ready;
    logic [1:0]            rsp_valid;
    logic [1:0]            elig;
    logic [1:0]            grant;
    logic [1:0]            pop;
    logic [1:0]            wr;
    logic                  issue;
    logic [CW-1:0]         credit_q [2];
    logic [CW-1:0]         credit_d [2];
    logic [CW-1:0]         count_q  [2];
    logic [CW-1:0]         count_d  [2];
    logic [PW-1:0]         rptr_q   [2];
    logic [PW-1:0]         wptr_q   [2];
    logic [63:0]           mem_q    [2][FIFO_DEPTH];
    logic [RD_LATENCY-1:0] tag_v_q;
    logic [RD_LATENCY-1:0] tag_id_q;
    logic                  last_q;   // requester granted by the most recent issue

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

    // A requester may only issue while it still owns a free slot in its FIFO, so a
    // returning read can never find its FIFO full.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            elig[n]      = req_valid[n] && (credit_q[n] != '0);
            rsp_valid[n] = (count_q[n] != '0);
            pop[n]       = rsp_valid[n] && rsp_ready[n];
        end
    end

    // With both eligible, the one not served last wins; last_q resets to 1 so req0 goes first.
    assign grant[1] = elig[1] && (!elig[0] || !last_q);
    assign grant[0] = elig[0] && !grant[1];
    assign issue    = (|elig) && bus.ram_addr_ready;

    // The oldest tag-pipe stage lines up with ram_data for that read.
    assign wr[0] = tag_v_q[RD_LATENCY-1] && !tag_id_q[RD_LATENCY-1];
    assign wr[1] = tag_v_q[RD_LATENCY-1] &&  tag_id_q[RD_LATENCY-1];

    assign bus.ram_addr_valid = |elig;
    assign bus.ram_addr       = grant[1] ? bus.req1_addr : (grant[0] ? bus.req0_addr : '0);
    assign bus.req0_ready     = grant[0] && bus.ram_addr_ready;
    assign bus.req1_ready     = grant[1] && bus.ram_addr_ready;
    assign bus.rsp0_valid     = rsp_valid[0];
    assign bus.rsp1_valid     = rsp_valid[1];
    // Storage is not reset; gating with valid keeps the data outputs at zero when empty.
    assign bus.rsp0_data      = rsp_valid[0] ? mem_q[0][rptr_q[0]] : '0;
    assign bus.rsp1_data      = rsp_valid[1] ? mem_q[1][rptr_q[1]] : '0;
    assign bus.busy           = (|tag_v_q) || (|rsp_valid);

    always_comb begin
        for (int n = 0; n < 2; n++) begin
            credit_d[n] = credit_q[n];
            count_d[n]  = count_q[n];
            if (issue && grant[n]) credit_d[n] = credit_d[n] - CW'(1);
            if (pop[n])            credit_d[n] = credit_d[n] + CW'(1);
            if (wr[n])             count_d[n]  = count_d[n] + CW'(1);
            if (pop[n])            count_d[n]  = count_d[n] - CW'(1);
        end
    end

    always_ff @(posedge csi_clk or negedge rsi_reset_n) begin
        if (!rsi_reset_n) begin
            for (int n = 0; n < 2; n++) begin
                credit_q[n] <= CW'(FIFO_DEPTH);
                count_q[n]  <= '0;
                rptr_q[n]   <= '0;
                wptr_q[n]   <= '0;
            end
            tag_v_q  <= '0;
            tag_id_q <= '0;
            last_q   <= 1'b1;
        end else begin
            for (int n = 0; n < 2; n++) begin
                credit_q[n] <= credit_d[n];
                count_q[n]  <= count_d[n];
                if (wr[n])  wptr_q[n] <= wptr_q[n] + PW'(1);
                if (pop[n]) rptr_q[n] <= rptr_q[n] + PW'(1);
            end
            tag_v_q  <= (tag_v_q << 1)  | RD_LATENCY'(issue);
            tag_id_q <= (tag_id_q << 1) | RD_LATENCY'(grant[1]);
            if (issue) last_q <= grant[1];
        end
    end

    // Write data lands in storage at the edge, so it becomes visible the next cycle.
    always_ff @(posedge csi_clk) begin
        for (int n = 0; n < 2; n++) begin
            if (wr[n]) mem_q[n][wptr_q[n]] <= bus.ram_data;
        end
    end

    always @(posedge csi_clk) begin
        if (rsi_reset_n) begin
            assert (count_q[0] <= CW'(FIFO_DEPTH) && count_q[1] <= CW'(FIFO_DEPTH));
        end
    end
endmodule
